// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, instruction field layout and
// fetch-sequencer state encoding.
package cpu_pkg;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 13;
  localparam int HALT_BIT = 12;
  localparam int LDI_BIT  = 11;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0] opc;
    logic       halt;
    logic       ldi;
    logic [7:0] imm;
  } dec_t;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational split of a 16-bit instruction word into its fields.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  // Reserved bits [10:8] carry no meaning and are deliberately dropped.
  logic unused_rsvd;
  assign unused_rsvd = ^instr[10:8];

  assign dec.opc  = instr[OPC_MSB:OPC_LSB];
  assign dec.halt = instr[HALT_BIT];
  assign dec.ldi  = instr[LDI_BIT];
  assign dec.imm  = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/cpu_fetch_sequencer.sv
// Fetch/decode/execute sequencer: reads program memory, drives the ALU and
// captures results into the accumulator and carry flag.
module cpu_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              instr_rd_en,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_valid,
  input  logic [15:0]       instr_data,
  output logic [2:0]        alu_sel,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  input  logic              alu_carry,
  output logic [7:0]        acc_out,
  output logic              carry_flag,
  output logic              busy,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              ldi_q;
  dec_t              dec;
  logic [7:0]        wb_acc;
  logic              wb_carry;

  cpu_instr_decode u_dec (
    .instr (instr_data),
    .dec   (dec)
  );

  // The address is the PC itself, which only moves in WB, so it is stable
  // for the whole FETCH..WAIT window.
  assign instr_addr = pc;

  // Div-by-zero and compare are pinned here so the architectural result does
  // not depend on how the external ALU handles those corner cases.
  always_comb begin
    wb_acc   = alu_result;
    wb_carry = alu_carry;
    if (ldi_q) begin
      wb_acc   = alu_b;
      wb_carry = carry_flag;
    end else if (alu_sel == OP_DIV && alu_b == 8'h00) begin
      wb_acc   = 8'h00;
      wb_carry = 1'b1;
    end else if (alu_sel == OP_CMP) begin
      wb_acc   = {7'b0, alu_a == alu_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= START_PC;
      acc_out     <= 8'h00;
      carry_flag  <= 1'b0;
      instr_rd_en <= 1'b0;
      alu_sel     <= 3'b000;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      ldi_q       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr_rd_en <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc          <= START_PC;
            acc_out     <= 8'h00;
            carry_flag  <= 1'b0;
            instr_rd_en <= 1'b1;
            busy        <= 1'b1;
            halted      <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          if (instr_valid) begin
            if (dec.halt) begin
              busy   <= 1'b0;
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              alu_sel <= dec.opc;
              alu_a   <= acc_out;
              alu_b   <= dec.imm;
              ldi_q   <= dec.ldi;
              state   <= EXEC;
            end
          end
        end
        EXEC: state <= WB;
        WB: begin
          acc_out     <= wb_acc;
          carry_flag  <= wb_carry;
          pc          <= pc + 1'b1;
          instr_rd_en <= 1'b1;
          state       <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Scoreboard bench: two sequencer instances (8-bit and 2-bit PC) with a
// latency-programmable memory model and a reference ALU.
module tb_cpu_fetch_sequencer;

  typedef struct {
    logic [7:0] acc;
    logic       c;
    logic [7:0] pc;
    int         nrd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       start, rd_en, vld, halted, busy, carry, alu_c;
  logic [1:0][7:0]  addr, acc, asel_ext, aa, ab, alu_r;
  logic [1:0][2:0]  asel;
  logic [1:0][15:0] data;
  logic [1:0]       addr1;

  logic [15:0] mem [2][256];
  int lat [2];
  int cnt [2];
  logic [7:0] a_q [2];
  logic spur [2];
  logic spur_pend [2];
  int rdc [2];
  logic hprev [2];

  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cpu_fetch_sequencer #(.ADDR_W(8), .START_ADDR(0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .instr_rd_en(rd_en[0]),
    .instr_addr(addr[0]), .instr_valid(vld[0]), .instr_data(data[0]),
    .alu_sel(asel[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_result(alu_r[0]),
    .alu_carry(alu_c[0]), .acc_out(acc[0]), .carry_flag(carry[0]),
    .busy(busy[0]), .halted(halted[0])
  );

  cpu_fetch_sequencer #(.ADDR_W(2), .START_ADDR(3)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .instr_rd_en(rd_en[1]),
    .instr_addr(addr1), .instr_valid(vld[1]), .instr_data(data[1]),
    .alu_sel(asel[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_result(alu_r[1]),
    .alu_carry(alu_c[1]), .acc_out(acc[1]), .carry_flag(carry[1]),
    .busy(busy[1]), .halted(halted[1])
  );

  assign addr[1] = {6'b0, addr1};

  // Reference ALU: {carry, result}
  function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (s)
      3'b000: return {1'b0, a} + {1'b0, b};
      3'b001: return {1'b0, a} - {1'b0, b};
      3'b010: return {1'b0, a & b};
      3'b011: return {1'b0, a | b};
      3'b100: return {1'b0, a ^ b};
      3'b101: begin p = a * b; return {|p[15:8], p[7:0]}; end
      3'b110: return (b == 8'h00) ? 9'h100 : {1'b0, a / b};
      default: return {1'b0, 7'b0, a == b};
    endcase
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_alu
    assign {alu_c[k], alu_r[k]} = alu_f(asel[k], aa[k], ab[k]);
    assign asel_ext[k] = {5'b0, asel[k]};
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: valid arrives lat cycles after the FETCH cycle; an optional
  // bogus HALT strobe follows one cycle later (lands in EXEC).
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0;
      if (spur_pend[k]) begin
        vld[k] = 1'b1; data[k] = 16'h1000; spur_pend[k] = 1'b0;
      end
      if (cnt[k] != 0) begin
        cnt[k]--;
        if (cnt[k] == 0) begin
          vld[k] = 1'b1; data[k] = mem[k][a_q[k]]; spur_pend[k] = spur[k];
        end
      end
      if (rd_en[k]) begin
        cnt[k] = lat[k]; a_q[k] = addr[k];
      end
    end
  end

  // Monitor: on each rising halted, pop and compare the expected state.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (start[k]) rdc[k] = 0;
      else if (rd_en[k]) rdc[k]++;
      if (halted[k] && !hprev[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          chk("unexpected_halt", 1, 0);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("u%0d acc", k), int'(acc[k]), int'(e.acc));
          chk($sformatf("u%0d carry", k), int'(carry[k]), int'(e.c));
          chk($sformatf("u%0d pc", k), int'(addr[k]), int'(e.pc));
          chk($sformatf("u%0d rd_pulses", k), rdc[k], e.nrd);
          chk($sformatf("u%0d busy_in_halt", k), int'(busy[k]), 0);
        end
      end
      hprev[k] = halted[k];
    end
  end

  task automatic run(input int k, input logic [7:0] eacc, input logic ec,
                     input logic [7:0] epc, input int enrd);
    exp_t e;
    int n;
    e.acc = eacc; e.c = ec; e.pc = epc; e.nrd = enrd;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    n = 0;
    while (!halted[k] && n < 300) begin
      @(posedge clk); #1 n++;
    end
    if (!halted[k]) begin
      chk("halt_timeout", 0, 1);
      if (k == 0) q0.delete(); else q1.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset();
    chk("rst acc", int'(acc[0]), 0);
    chk("rst carry", int'(carry[0]), 0);
    chk("rst busy", int'(busy[0]), 0);
    chk("rst halted", int'(halted[0]), 0);
    chk("rst rd_en", int'(rd_en[0]), 0);
    chk("rst alu_sel", int'(asel_ext[0]), 0);
    chk("rst alu_a", int'(aa[0]), 0);
    chk("rst alu_b", int'(ab[0]), 0);
    chk("rst addr", int'(addr[0]), 0);
  endtask

  task automatic load0(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2);
    mem[0][0] = i0; mem[0][1] = i1; mem[0][2] = i2;
  endtask

  initial begin
    rst = 1'b1; start = 2'b00;
    for (int k = 0; k < 2; k++) begin
      lat[k] = 1; cnt[k] = 0; spur[k] = 1'b0; spur_pend[k] = 1'b0;
      rdc[k] = 0; hprev[k] = 1'b0; vld[k] = 1'b0; data[k] = 16'h0;
      for (int a = 0; a < 256; a++) mem[k][a] = 16'h1000;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1 chk_reset();
    @(posedge clk); #1 rst = 1'b0;

    // LDI 5, ADD 3 (reserved bits set), HALT
    load0(16'h0805, 16'h0703, 16'h1000);
    run(0, 8'h08, 1'b0, 8'd2, 3);
    load0(16'h08F0, 16'h0020, 16'h1000);
    run(0, 8'h10, 1'b1, 8'd2, 3);
    load0(16'h0810, 16'hA020, 16'h1000);
    run(0, 8'h00, 1'b1, 8'd2, 3);
    load0(16'h0809, 16'hC000, 16'h1000);
    run(0, 8'h00, 1'b1, 8'd2, 3);
    load0(16'h0807, 16'hE007, 16'h1000);
    run(0, 8'h01, 1'b0, 8'd2, 3);

    // Latency 4 with a stray strobe during EXEC
    lat[0] = 4; spur[0] = 1'b1;
    load0(16'h0805, 16'h0003, 16'h1000);
    run(0, 8'h08, 1'b0, 8'd2, 3);
    spur[0] = 1'b0;

    // 2-bit PC wraps 3 -> 0; second run restarts at 3 with acc cleared
    mem[1][3] = 16'h0801; mem[1][0] = 16'h0001; mem[1][1] = 16'h1000;
    run(1, 8'h02, 1'b0, 8'd1, 3);
    run(1, 8'h02, 1'b0, 8'd1, 3);

    // Reset while WAITing on a slow read; the late response must be dropped
    lat[0] = 8;
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("wait busy", int'(busy[0]), 1);
    rst = 1'b1;
    @(negedge clk); #1 chk_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("stale busy", int'(busy[0]), 0);
    chk("stale halted", int'(halted[0]), 0);
    chk("stale acc", int'(acc[0]), 0);
    chk("stale cnt_drained", cnt[0], 0);
    lat[0] = 1;
    run(0, 8'h08, 1'b0, 8'd2, 3);

    repeat (3) @(posedge clk);
    chk("queue_empty", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
